// File: rtl/vending_machine_multi.sv
// vending_machine_multi
//   N-product vending controller with per-product price and stock. Accepts
//   1/2/5 zl coins, vends once credit covers the selected price, and returns
//   change greedily (5, 2, 1) as one coin pulse per cycle. Cancel refunds all
//   credit. Every output is a register.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   BTN         product select buttons (level, edge detected)
//   cancel      refund request (level)
//   restock     reload every stock counter (level, IDLE only)
//   Money_in    coin code 001=1, 010=2, 100=5, 000=none
//   product     one-cycle one-hot dispense pulse
//   delivered   one-cycle pulse coincident with product
//   LED         selected-product indicator
//   sold_out    per-product stock==0
//   credit      current credit in zl
//   coin_reject one-cycle pulse when a coin is refused
//   coin_out    one-cycle change coin, Money_in encoding
//   busy        high in VEND and CHANGE
module vending_machine_multi #(
   parameter int                             N_PRODUCTS = 3,
   parameter int                             CREDIT_W   = 8,
   parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICES     = {8'd5, 8'd4, 8'd3},
   parameter int                             MAX_CREDIT = 20,
   parameter int                             STOCK_W    = 4,
   parameter int                             STOCK_INIT = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_PRODUCTS-1:0] BTN,
   input  logic                  cancel,
   input  logic                  restock,
   input  logic [2:0]            Money_in,
   output logic [N_PRODUCTS-1:0] product,
   output logic                  delivered,
   output logic [N_PRODUCTS-1:0] LED,
   output logic [N_PRODUCTS-1:0] sold_out,
   output logic [CREDIT_W-1:0]   credit,
   output logic                  coin_reject,
   output logic [2:0]            coin_out,
   output logic                  busy
);

   localparam int SEL_W = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1;
   localparam logic [CREDIT_W:0]   MAXC  = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [STOCK_W-1:0]  SINIT = STOCK_W'(STOCK_INIT);
   localparam logic [STOCK_W-1:0]  S_ONE = STOCK_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_SELECTED, S_VEND, S_CHANGE} state_t;

   state_t                             r_state;
   logic [SEL_W-1:0]                   r_sel;
   logic [2:0]                         r_money_prev;
   logic [N_PRODUCTS-1:0]              r_btn_prev;
   logic [N_PRODUCTS-1:0][STOCK_W-1:0] r_stock;

   logic                  w_coin_evt, w_coin_ok, w_coin_acc, w_coin_rej;
   logic [CREDIT_W-1:0]   w_coin_val, w_credit_in, w_price, w_chg_val;
   logic [CREDIT_W:0]     w_credit_sum;
   logic [2:0]            w_chg_code;
   logic [N_PRODUCTS-1:0] w_btn_edge;
   logic                  w_btn_hit;
   logic [SEL_W-1:0]      w_btn_idx;

   // Coin decode; only one-hot codes carry value.
   always_comb begin
      w_coin_val = '0;
      w_coin_ok  = 1'b1;
      case (Money_in)
         3'b001:  w_coin_val = CREDIT_W'(1);
         3'b010:  w_coin_val = CREDIT_W'(2);
         3'b100:  w_coin_val = CREDIT_W'(5);
         default: w_coin_ok  = 1'b0;
      endcase
   end

   assign w_coin_evt   = (Money_in != 3'b000) && (r_money_prev == 3'b000);
   assign w_credit_sum = {1'b0, credit} + {1'b0, w_coin_val};
   assign w_coin_acc   = w_coin_evt && w_coin_ok && (w_credit_sum <= MAXC) &&
                         (r_state == S_IDLE || r_state == S_SELECTED);
   assign w_coin_rej   = w_coin_evt && !w_coin_acc;
   // Credit after this cycle's coin; everything that subtracts builds on it
   // so a coin landing together with cancel or vend is never lost.
   assign w_credit_in  = w_coin_acc ? w_credit_sum[CREDIT_W-1:0] : credit;

   // Sold-out products never produce a usable edge.
   assign w_btn_edge = BTN & ~r_btn_prev & ~sold_out;

   // Descending scan so the lowest set index is the one left standing.
   always_comb begin
      w_btn_hit = 1'b0;
      w_btn_idx = '0;
      for (int i = N_PRODUCTS - 1; i >= 0; i--) begin
         if (w_btn_edge[i]) begin
            w_btn_hit = 1'b1;
            w_btn_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      w_price = '0;
      for (int i = 0; i < N_PRODUCTS; i++)
         if (r_sel == SEL_W'(i)) w_price = PRICES[i*CREDIT_W +: CREDIT_W];
   end

   // Largest coin not exceeding the credit to be refunded.
   always_comb begin
      w_chg_val  = '0;
      w_chg_code = 3'b000;
      if (w_credit_in >= CREDIT_W'(5)) begin
         w_chg_val = CREDIT_W'(5); w_chg_code = 3'b100;
      end else if (w_credit_in >= CREDIT_W'(2)) begin
         w_chg_val = CREDIT_W'(2); w_chg_code = 3'b010;
      end else if (w_credit_in != '0) begin
         w_chg_val = CREDIT_W'(1); w_chg_code = 3'b001;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_sel        <= '0;
         r_money_prev <= 3'b000;
         r_btn_prev   <= '0;
         r_stock      <= {N_PRODUCTS{SINIT}};
         product      <= '0;
         delivered    <= 1'b0;
         LED          <= '0;
         sold_out     <= '0;
         credit       <= '0;
         coin_reject  <= 1'b0;
         coin_out     <= 3'b000;
         busy         <= 1'b0;
      end else begin
         r_money_prev <= Money_in;
         r_btn_prev   <= BTN;
         coin_reject  <= w_coin_rej;
         product      <= '0;
         delivered    <= 1'b0;
         coin_out     <= 3'b000;
         credit       <= w_credit_in;
         case (r_state)
            S_IDLE: begin
               if (cancel && w_credit_in != '0) begin
                  // First refund coin goes out on the same edge that enters CHANGE.
                  r_state  <= S_CHANGE;
                  busy     <= 1'b1;
                  coin_out <= w_chg_code;
                  credit   <= w_credit_in - w_chg_val;
               end else if (w_btn_hit) begin
                  r_sel   <= w_btn_idx;
                  LED     <= N_PRODUCTS'(1) << w_btn_idx;
                  r_state <= S_SELECTED;
               end else if (restock) begin
                  r_stock  <= {N_PRODUCTS{SINIT}};
                  sold_out <= '0;
               end
            end
            S_SELECTED: begin
               if (cancel) begin
                  LED <= '0;
                  if (w_credit_in != '0) begin
                     r_state  <= S_CHANGE;
                     busy     <= 1'b1;
                     coin_out <= w_chg_code;
                     credit   <= w_credit_in - w_chg_val;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else if (w_btn_hit) begin
                  r_sel <= w_btn_idx;
                  LED   <= N_PRODUCTS'(1) << w_btn_idx;
               end else if (credit >= w_price) begin
                  // Registered credit: a coin landing now is counted first and
                  // only feeds the check on the next edge.
                  r_state          <= S_VEND;
                  busy             <= 1'b1;
                  product          <= N_PRODUCTS'(1) << r_sel;
                  delivered        <= 1'b1;
                  credit           <= w_credit_in - w_price;
                  r_stock[r_sel]   <= r_stock[r_sel] - S_ONE;
                  sold_out[r_sel]  <= (r_stock[r_sel] == S_ONE);
               end
            end
            S_VEND: begin
               LED <= '0;
               if (w_credit_in != '0) begin
                  r_state  <= S_CHANGE;
                  coin_out <= w_chg_code;
                  credit   <= w_credit_in - w_chg_val;
               end else begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            S_CHANGE: begin
               // Each CHANGE cycle shows one coin; credit already reflects it.
               if (w_credit_in != '0) begin
                  coin_out <= w_chg_code;
                  credit   <= w_credit_in - w_chg_val;
               end else begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vending_machine_multi.sv
module tb_vending_machine_multi;

   logic       clk;
   logic       reset;
   logic [2:0] BTN;
   logic       cancel, restock;
   logic [2:0] Money_in;
   logic [2:0] product, LED, sold_out, coin_out;
   logic       delivered, coin_reject, busy;
   logic [7:0] credit;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [2:0] prod;
      logic       dlv;
      logic [2:0] cout;
      logic       rej;
   } ev_t;

   ev_t exp_q[$];

   vending_machine_multi dut (
      .clk(clk), .reset(reset), .BTN(BTN), .cancel(cancel), .restock(restock),
      .Money_in(Money_in), .product(product), .delivered(delivered), .LED(LED),
      .sold_out(sold_out), .credit(credit), .coin_reject(coin_reject),
      .coin_out(coin_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ev_t ev_prod(input logic [2:0] p);
      return {p, 1'b1, 3'b000, 1'b0};
   endfunction
   function automatic ev_t ev_coin(input logic [2:0] c);
      return {3'b000, 1'b0, c, 1'b0};
   endfunction
   function automatic ev_t ev_rej();
      return {3'b000, 1'b0, 3'b000, 1'b1};
   endfunction

   // Monitor: every output event is matched against the next expected one.
   always @(negedge clk) begin
      ev_t got, e;
      if (reset && (delivered || product != 3'b000 || coin_out != 3'b000 || coin_reject)) begin
         got = {product, delivered, coin_out, coin_reject};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event got prod=%b dlv=%b cout=%b rej=%b at %0t",
                     got.prod, got.dlv, got.cout, got.rej, $time);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_bad++;
               $display("FAIL event got prod=%b dlv=%b cout=%b rej=%b want prod=%b dlv=%b cout=%b rej=%b at %0t",
                        got.prod, got.dlv, got.cout, got.rej, e.prod, e.dlv, e.cout, e.rej, $time);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic coin(input logic [2:0] c);
      Money_in = c;
      cyc(1);
      Money_in = 3'b000;
      cyc(1);
   endtask

   initial begin
      reset = 1'b0; BTN = '0; cancel = 1'b0; restock = 1'b0; Money_in = 3'b000;
      cyc(2);
      chk("rst_credit",   credit, 0);
      chk("rst_busy",     busy, 0);
      chk("rst_led",      LED, 0);
      chk("rst_soldout",  sold_out, 0);
      chk("rst_coin_out", coin_out, 0);
      reset = 1'b1;
      cyc(1);

      // Basic vend: product 0 (price 3), pay 2+2, change 1.
      BTN = 3'b001; cyc(1);
      chk("basic_led", LED, 3'b001);
      BTN = 3'b000; cyc(1);
      Money_in = 3'b010; cyc(1);
      chk("basic_credit2", credit, 2);
      Money_in = 3'b000; cyc(1);
      exp_q.push_back(ev_prod(3'b001));
      exp_q.push_back(ev_coin(3'b001));
      Money_in = 3'b010; cyc(1);
      chk("basic_credit4", credit, 4);
      Money_in = 3'b000; cyc(1);
      chk("basic_vend_busy", busy, 1);
      cyc(2);
      chk("basic_credit0", credit, 0);
      chk("basic_idle", busy, 0);

      // Big change: prepay 5, select product 2 (price 5), then 2+1 and cancel.
      exp_q.push_back(ev_prod(3'b100));
      coin(3'b100);
      chk("big_prepay", credit, 5);
      BTN = 3'b100; cyc(1);
      BTN = 3'b000; cyc(1);
      chk("big_vend_credit", credit, 0);
      cyc(1);
      coin(3'b010);
      coin(3'b001);
      chk("big_credit3", credit, 3);
      exp_q.push_back(ev_coin(3'b010));
      exp_q.push_back(ev_coin(3'b001));
      cancel = 1'b1; cyc(1); cancel = 1'b0;
      cyc(3);
      chk("big_refunded", credit, 0);

      // Overflow and invalid coins.
      repeat (4) coin(3'b100);
      chk("ovf_credit20", credit, 20);
      exp_q.push_back(ev_rej());
      coin(3'b100);
      chk("ovf_credit_kept", credit, 20);
      exp_q.push_back(ev_rej());
      coin(3'b011);
      chk("bad_code_credit", credit, 20);
      repeat (4) exp_q.push_back(ev_coin(3'b100));
      cancel = 1'b1; cyc(1); cancel = 1'b0;
      cyc(5);
      chk("ovf_refunded", credit, 0);
      Money_in = 3'b001; cyc(5);
      Money_in = 3'b000; cyc(1);
      chk("held_coin_once", credit, 1);
      exp_q.push_back(ev_coin(3'b001));
      cancel = 1'b1; cyc(1); cancel = 1'b0;
      cyc(3);
      chk("held_refunded", credit, 0);

      // Sold out: fresh stock, buy product 0 five times (pay 5, change 2).
      restock = 1'b1; cyc(1); restock = 1'b0; cyc(1);
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(ev_prod(3'b001));
         exp_q.push_back(ev_coin(3'b010));
         coin(3'b100);
         BTN = 3'b001; cyc(1);
         BTN = 3'b000; cyc(1);
         cyc(3);
      end
      chk("soldout_set", sold_out, 3'b001);
      BTN = 3'b001; cyc(1);
      chk("soldout_led", LED, 0);
      chk("soldout_busy", busy, 0);
      BTN = 3'b000; cyc(1);
      restock = 1'b1; cyc(1); restock = 1'b0;
      chk("restock_clear", sold_out, 0);

      // Simultaneous buttons, then reselect and pay exact.
      BTN = 3'b110; cyc(1);
      chk("multi_btn_led", LED, 3'b010);
      BTN = 3'b010; cyc(1);
      BTN = 3'b110; cyc(1);
      chk("reselect_led", LED, 3'b100);
      BTN = 3'b000; cyc(1);
      exp_q.push_back(ev_prod(3'b100));
      coin(3'b100);
      cyc(3);
      chk("reselect_credit", credit, 0);
      chk("reselect_led_off", LED, 0);

      // Reset during CHANGE: credit 8, cancel, reset after first coin.
      coin(3'b100); coin(3'b010); coin(3'b001);
      chk("rc_credit8", credit, 8);
      exp_q.push_back(ev_coin(3'b100));
      cancel = 1'b1; cyc(1); cancel = 1'b0;
      chk("rc_first_coin", coin_out, 3'b100);
      @(negedge clk); #1;
      reset = 1'b0; #1;
      chk("rc_outs_zero", {product, delivered, LED, coin_reject, coin_out, busy}, 0);
      chk("rc_credit_zero", credit, 0);
      @(negedge clk);
      reset = 1'b1;
      cyc(3);
      chk("rc_after_credit", credit, 0);
      chk("rc_after_busy", busy, 0);
      chk("rc_after_coin", coin_out, 0);

      cyc(2);
      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_vec++;
         n_bad++;
         $display("FAIL missing_event want prod=%b cout=%b rej=%b", e.prod, e.cout, e.rej);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
